// File: rtl/ex_mul_div_if.sv
// Request/result bundle between the EX-stage pipeline control and the ex_mul_div unit.
interface ex_mul_div_if #(
    parameter int unsigned XLEN = 64
);
    logic            valid_i;
    logic [2:0]      op_i;
    logic            word_i;
    logic [XLEN-1:0] src1_i;
    logic [XLEN-1:0] src2_i;
    logic            flush_i;
    logic            stall_req_o;
    logic            result_valid_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, op_i, word_i, src1_i, src2_i, flush_i,
        input  stall_req_o, result_valid_o, result_o
    );

    modport slave (
        input  valid_i, op_i, word_i, src1_i, src2_i, flush_i,
        output stall_req_o, result_valid_o, result_o
    );
endinterface

// File: rtl/ex_mul_div.sv
// Iterative RV64M multiply/divide unit (shift-add multiply, restoring divide) for the EX stage.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle product.
module ex_mul_div #(
    parameter int unsigned XLEN = 64
) (
    input  logic        clk,
    input  logic        rst,
    ex_mul_div_if.slave bus
);
    localparam int unsigned CW        = $clog2(XLEN + 1);
    localparam logic [2:0]  OP_MUL    = 3'b000;
    localparam logic [2:0]  OP_MULHU  = 3'b011;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2:0]        op_q, op_d;
    logic              word_q, word_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] mul_sel(input logic [2:0] op, input logic word,
                                                input logic [2*XLEN-1:0] p);
        if (word)
            return sext32(p[31:0]);
        if (op == OP_MUL)
            return p[XLEN-1:0];
        return p[2*XLEN-1:XLEN];
    endfunction

    logic            is_div, is_rem, a_signed, b_signed, word_eff, neg_a, neg_b;
    logic            div_zero, div_ovf, special, fast_mul, accept;
    logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, min_neg, sp_sel, special_res, fast_res;

    always_comb begin
        is_div   = bus.op_i[2];
        is_rem   = bus.op_i[2] & bus.op_i[1];
        a_signed = is_div ? ~bus.op_i[0] : (bus.op_i != OP_MULHU);
        b_signed = is_div ? ~bus.op_i[0] : ~bus.op_i[1];
        word_eff = bus.word_i & (is_div | (bus.op_i == OP_MUL));

        if (word_eff) begin
            a_ext = a_signed ? sext32(bus.src1_i[31:0]) : {{(XLEN-32){1'b0}}, bus.src1_i[31:0]};
            b_ext = b_signed ? sext32(bus.src2_i[31:0]) : {{(XLEN-32){1'b0}}, bus.src2_i[31:0]};
        end else begin
            a_ext = bus.src1_i;
            b_ext = bus.src2_i;
        end

        neg_a = a_signed & a_ext[XLEN-1];
        neg_b = b_signed & b_ext[XLEN-1];
        abs_a = neg_a ? ('0 - a_ext) : a_ext;
        abs_b = neg_b ? ('0 - b_ext) : b_ext;

        // Overflow test uses the extended operand, so the W form compares against sext(0x8000_0000).
        min_neg  = word_eff ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = is_div & (b_ext == '0);
        div_ovf  = is_div & ~bus.op_i[0] & (a_ext == min_neg) & (b_ext == '1);
        special  = div_zero | div_ovf;

        if (is_rem)
            sp_sel = div_zero ? a_ext : '0;
        else
            sp_sel = div_zero ? '1 : a_ext;
        special_res = word_eff ? sext32(sp_sel[31:0]) : sp_sel;

        accept = (state_q == S_IDLE) & bus.valid_i & ~bus.flush_i;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN+1:0] fast_p;

    always_comb begin
        fast_a   = {a_signed & a_ext[XLEN-1], a_ext};
        fast_b   = {b_signed & b_ext[XLEN-1], b_ext};
        fast_p   = fast_a * fast_b;
        fast_mul = ~is_div;
        fast_res = mul_sel(bus.op_i, word_eff, fast_p[2*XLEN-1:0]);
    end
`else
    always_comb begin
        fast_mul = 1'b0;
        fast_res = '0;
    end
`endif

    logic [XLEN:0]     mul_sum, rem_shift, rem_diff;
    logic [2*XLEN-1:0] acc_step, prod;
    logic [XLEN-1:0]   quo, rem, div_sel, busy_res;

    // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
        rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, opb_q};

        if (op_q[2]) begin
            if (!rem_diff[XLEN])
                acc_step = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else
                acc_step = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else if (acc_q[0]) begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end else begin
            acc_step = {1'b0, acc_q[2*XLEN-1:1]};
        end

        // A 32-step multiply leaves the product XLEN-32 bits above the accumulator LSB.
        prod = word_q ? (acc_step >> (XLEN - 32)) : acc_step;
        if (neg_res_q)
            prod = '0 - prod;

        quo = acc_step[XLEN-1:0];
        rem = acc_step[2*XLEN-1:XLEN];
        if (neg_res_q)
            quo = '0 - quo;
        if (neg_rem_q)
            rem = '0 - rem;
        div_sel = op_q[1] ? rem : quo;

        if (op_q[2])
            busy_res = word_q ? sext32(div_sel[31:0]) : div_sel;
        else
            busy_res = mul_sel(op_q, word_q, prod);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (special | fast_mul) ? S_DONE : S_BUSY;
            S_BUSY:  if (cnt_q == CW'(1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush_i)
            state_d = S_IDLE;
    end

    always_comb begin
        bus.stall_req_o    = accept | (~bus.flush_i & (state_q == S_BUSY));
        bus.result_valid_o = ~bus.flush_i & (state_q == S_DONE);
        bus.result_o       = result_q;
    end

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        op_d      = op_q;
        word_d    = word_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        if (accept) begin
            op_d      = bus.op_i;
            word_d    = word_eff;
            neg_res_d = neg_a ^ neg_b;
            neg_rem_d = neg_a;
            cnt_d     = word_eff ? CW'(32) : CW'(XLEN);
            if (is_div) begin
                opb_d = abs_b;
                acc_d = {{XLEN{1'b0}}, (word_eff ? (abs_a << (XLEN - 32)) : abs_a)};
            end else begin
                opb_d = abs_a;
                acc_d = {{XLEN{1'b0}}, abs_b};
            end
            if (special)
                result_d = special_res;
            else if (fast_mul)
                result_d = fast_res;
        end else if ((state_q == S_BUSY) && !bus.flush_i) begin
            acc_d = acc_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1))
                result_d = busy_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            op_q      <= '0;
            word_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            op_q      <= op_d;
            word_q    <= word_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end
endmodule

// File: tb/tb_ex_mul_div.sv
// Self-checking bench for ex_mul_div: directed RV64M cases plus random ops against an arithmetic model.
module tb_ex_mul_div;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_mul_div_if #(.XLEN(64)) bus ();
    ex_mul_div #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    int unsigned total = 0;
    int unsigned passed = 0;
    logic [63:0] last_exp = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference result from plain wide arithmetic and the RISC-V corner-case rules.
    function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] p;
        logic [127:0] up;
        logic [31:0] a32, b32;
        int x, y;
        longint sa, sb;
        a32 = a[31:0];
        b32 = b[31:0];
        x = a32;
        y = b32;
        sa = a;
        sb = b;
        case (op)
            3'b000: if (w) return sx32(a32 * b32); else return a * b;
            3'b001: begin
                p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
                return p[127:64];
            end
            3'b010: begin
                p = $signed({{64{a[63]}}, a}) * $signed({64'd0, b});
                return p[127:64];
            end
            3'b011: begin
                up = {64'd0, a} * {64'd0, b};
                return up[127:64];
            end
            3'b100: begin
                if (w) begin
                    if (y == 0) return '1;
                    if (a32 == 32'h8000_0000 && y == -1) return sx32(a32);
                    return sx32(x / y);
                end
                if (sb == 0) return '1;
                if (a == 64'h8000_0000_0000_0000 && sb == -1) return a;
                return sa / sb;
            end
            3'b101: begin
                if (w) return (b32 == 0) ? '1 : sx32(a32 / b32);
                return (b == 0) ? '1 : a / b;
            end
            3'b110: begin
                if (w) begin
                    if (y == 0) return sx32(a32);
                    if (a32 == 32'h8000_0000 && y == -1) return 64'd0;
                    return sx32(x % y);
                end
                if (sb == 0) return a;
                if (a == 64'h8000_0000_0000_0000 && sb == -1) return 64'd0;
                return sa % sb;
            end
            default: begin
                if (w) return (b32 == 0) ? sx32(a32) : sx32(a32 % b32);
                return (b == 0) ? a : a % b;
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        if (op[2]) begin
            if (w ? (b[31:0] == 32'd0) : (b == 64'd0)) return 1;
            if (!op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                             : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)))
                return 1;
            return w ? 33 : 65;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 1;
`else
        return (w && op == 3'b000) ? 33 : 65;
`endif
    endfunction

    task automatic do_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input string tag);
        logic [63:0] exp;
        int n, pulses;
        exp = model(op, w, a, b);
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.word_i  = w;
        bus.src1_i  = a;
        bus.src2_i  = b;
        n = 0;
        pulses = 0;
        @(negedge clk);
        while (bus.stall_req_o === 1'b1 && n < 200) begin
            if (bus.result_valid_o !== 1'b0) pulses++;
            n++;
            @(negedge clk);
        end
        chk({tag, " stall_cycles"}, 64'(n), 64'(exp_lat(op, w, a, b)));
        chk({tag, " early_pulse"}, 64'(pulses), 64'd0);
        chk({tag, " result_valid"}, {63'd0, bus.result_valid_o}, 64'd1);
        chk({tag, " result"}, bus.result_o, exp);
        last_exp = exp;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        bus.valid_i = 1'b0;
        @(negedge clk);
        chk({tag, " idle_stall"}, {63'd0, bus.stall_req_o}, 64'd0);
        chk({tag, " idle_valid"}, {63'd0, bus.result_valid_o}, 64'd0);
        chk({tag, " idle_hold"}, bus.result_o, last_exp);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'($urandom_range(0, 20));
            4: return {$urandom, 32'h8000_0000};
            5: return 64'd0 - 64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, stalls;
        logic [2:0] rop;
        logic rw;
        rst = 1'b1;
        bus.valid_i = 1'b0;
        bus.op_i    = 3'b000;
        bus.word_i  = 1'b0;
        bus.src1_i  = '0;
        bus.src2_i  = '0;
        bus.flush_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset result", bus.result_o, 64'd0);
        chk("reset valid", {63'd0, bus.result_valid_o}, 64'd0);
        chk("reset stall", {63'd0, bus.stall_req_o}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        do_op(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, "mul_7x-3");
        idle_chk("after_mul");
        do_op(3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "mulhu_max");
        do_op(3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "mulh_m1");
        do_op(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "div_-7_2");
        do_op(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "rem_-7_2");
        do_op(3'b101, 1'b0, 64'd100, 64'd0, "divu_by0");
        do_op(3'b110, 1'b0, 64'd5, 64'd0, "rem_by0");
        do_op(3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "div_ovf");
        do_op(3'b110, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "remw_ovf");
        do_op(3'b100, 1'b1, 64'h0000_0001_FFFF_FFF8, 64'd2, "divw");
        do_op(3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, "mulhsu");
        idle_chk("after_directed");

        // Flush in the tenth busy cycle of a divide.
        bus.valid_i = 1'b1;
        bus.op_i    = 3'b101;
        bus.word_i  = 1'b0;
        bus.src1_i  = 64'd1000;
        bus.src2_i  = 64'd7;
        repeat (10) @(posedge clk);
        #1 bus.flush_i = 1'b1;
        @(negedge clk);
        chk("flush stall", {63'd0, bus.stall_req_o}, 64'd0);
        chk("flush valid", {63'd0, bus.result_valid_o}, 64'd0);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        pulses = 0;
        stalls = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.result_valid_o !== 1'b0) pulses++;
            if (bus.stall_req_o !== 1'b0) stalls++;
        end
        chk("flush no_pulse", 64'(pulses), 64'd0);
        chk("flush no_stall", 64'(stalls), 64'd0);
        chk("flush hold", bus.result_o, last_exp);
        @(posedge clk);
        #1;
        do_op(3'b101, 1'b0, 64'd9, 64'd3, "divu_after_flush");

        // Reset pulsed in the middle of a multiply, then a second multiply straight after.
        bus.valid_i = 1'b1;
        bus.op_i    = 3'b000;
        bus.word_i  = 1'b0;
        bus.src1_i  = 64'd12345;
        bus.src2_i  = 64'd678;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.valid_i = 1'b0;
        @(negedge clk);
        chk("rst_mid result", bus.result_o, 64'd0);
        chk("rst_mid valid", {63'd0, bus.result_valid_o}, 64'd0);
        chk("rst_mid stall", {63'd0, bus.stall_req_o}, 64'd0);
        @(posedge clk);
        #1;
        do_op(3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FF00, 64'd1000, "mul_after_rst");
        do_op(3'b000, 1'b1, 64'h0000_0001_0000_0003, 64'hFFFF_FFFF_FFFF_FFFB, "mulw");

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            rw  = 1'($urandom_range(0, 1));
            do_op(rop, rw, rnd_operand(), rnd_operand(), $sformatf("rand%0d", i));
            if ($urandom_range(0, 2) == 0)
                idle_chk($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
